vdic_alu_arbiter: RTL and testbench

- Frame-level round-robin arbiter that shares the single command ALU (NOP/AND/OR/XOR/ADD/SUB, max 9 data words per command) between N_REQ requesters.
- Grants one requester for a whole frame: data words followed by one command word.
- Forwards the frame to the ALU, waits for the ALU response, and routes result and status back to the granted requester.
- Enforces the argument limit locally so the ALU never receives an overlong frame.

---
 rtl/vdic_dut_pkg.sv | 28 ++
 rtl/vdic_alu_arbiter_if.sv | 50 +++++
 rtl/vdic_rr_picker.sv | 36 +++
 rtl/vdic_alu_arbiter.sv | 173 +++++++++++++++++
 tb/tb_vdic_alu_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vdic_dut_pkg.sv
// Shared definitions for the command-ALU arbiter slice.
// Holds the ALU command/status encodings, the per-frame argument limit
// and the arbiter state encoding.
package vdic_dut_pkg;

  localparam int MAX_ARGS = 9;

  typedef enum logic [7:0] {
    CMD_NOP = 8'h00,
    CMD_AND = 8'h01,
    CMD_OR  = 8'h02,
    CMD_XOR = 8'h03,
    CMD_ADD = 8'h04,
    CMD_SUB = 8'h05
  } command_t;

  typedef enum logic [7:0] {
    S_NO_ERROR            = 8'h00,
    S_MISSING_ARG         = 8'h01,
    S_DATA_STACK_OVERFLOW = 8'h02,
    S_OUTPUT_OVERFLOW     = 8'h04,
    S_RSP_TIMEOUT         = 8'h08,
    S_INVALID_COMMAND     = 8'h10
  } status_t;

  typedef enum logic [2:0] {IDLE, FWD, ABORT, DRAIN, WAIT_RSP, RSP} arb_state_t;

endpackage

// File: rtl/vdic_alu_arbiter_if.sv
// Bus bundles for the arbiter.
//   vdic_req_if : requester side. master = requesters, slave = arbiter.
//     req_valid/req_ready/req_data/req_is_cmd carry frame words,
//     rsp_valid/rsp_ready/rsp_data/rsp_status return the ALU answer.
//   vdic_alu_if : ALU side. master = arbiter, slave = ALU.
//     alu_valid/alu_ready/alu_data/alu_is_cmd carry words to the ALU,
//     alu_rsp_valid/alu_rsp_data/alu_rsp_status is the one-cycle response.
interface vdic_req_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_is_cmd;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]       rsp_data;
  logic [7:0]              rsp_status;

  modport master (
    output req_valid, req_data, req_is_cmd, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_status
  );
  modport slave (
    input  req_valid, req_data, req_is_cmd, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_status
  );
endinterface

interface vdic_alu_if #(
  parameter int DATA_W = 32
);
  logic              alu_valid;
  logic              alu_ready;
  logic [DATA_W-1:0] alu_data;
  logic              alu_is_cmd;
  logic              alu_rsp_valid;
  logic [DATA_W-1:0] alu_rsp_data;
  logic [7:0]        alu_rsp_status;

  modport master (
    output alu_valid, alu_data, alu_is_cmd,
    input  alu_ready, alu_rsp_valid, alu_rsp_data, alu_rsp_status
  );
  modport slave (
    input  alu_valid, alu_data, alu_is_cmd,
    output alu_ready, alu_rsp_valid, alu_rsp_data, alu_rsp_status
  );
endinterface

// File: rtl/vdic_rr_picker.sv
// Combinational round-robin picker.
//   valid_i : request vector
//   ptr_i   : last served requester; scan starts at ptr_i+1 with wrap
//   gnt_o   : one-hot winner (0 when nothing valid)
//   any_o   : at least one request valid
module vdic_rr_picker #(
  parameter int N_REQ = 2,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             any_o
);

  int best_d, best_i, d;

  // Each requester's distance from the pointer; the closest valid one wins.
  always_comb begin
    best_d = N_REQ;
    best_i = 0;
    d      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      d = (i + 2*N_REQ - 1 - int'(ptr_i)) % N_REQ;
      if (valid_i[i] && d < best_d) begin
        best_d = d;
        best_i = i;
      end
    end
    any_o = (best_d < N_REQ);
    gnt_o = '0;
    for (int i = 0; i < N_REQ; i++)
      if (any_o && i == best_i) gnt_o[i] = 1'b1;
  end

endmodule

// File: rtl/vdic_alu_arbiter.sv
// Frame-level round-robin arbiter in front of the single command ALU.
// A requester owns the ALU for a whole frame (data words + one command
// word); the answer is routed back to it. Frames longer than MAX_ARGS
// are cut: the ALU gets a NOP to clear its stack, the rest of the frame
// is drained, and the requester sees S_DATA_STACK_OVERFLOW.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   req        : vdic_req_if.slave (requester words and responses)
//   alu        : vdic_alu_if.master (words to ALU, ALU response)
//   grant      : one-hot current owner, 0 in IDLE
//   busy       : state is not IDLE
// Optional: define VDIC_ALU_ARB_RSP_TIMEOUT_EN to add a response watchdog
// that answers S_RSP_TIMEOUT after TIMEOUT_CYC cycles in WAIT_RSP.
module vdic_alu_arbiter
  import vdic_dut_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int DATA_W      = 32,
  parameter int MAX_ARGS    = vdic_dut_pkg::MAX_ARGS,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  vdic_req_if.slave        req,
  vdic_alu_if.master       alu,
  output logic [N_REQ-1:0] grant,
  output logic             busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_ARGS + 1);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("vdic_alu_arbiter: unsupported N_REQ or TIMEOUT_CYC");
  end

  arb_state_t        state_q;
  logic [N_REQ-1:0]  grant_q;
  logic [PW-1:0]     ptr_q;
  logic [CW-1:0]     cnt_q;
  logic              ovf_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [7:0]        rsp_status_q;

`ifdef VDIC_ALU_ARB_RSP_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wd_q;
`endif

  logic [N_REQ-1:0]  pick_gnt;
  logic              pick_any;
  logic              sel_valid, sel_cmd, at_max;
  logic [DATA_W-1:0] sel_data;
  logic [PW-1:0]     g_idx;

  vdic_rr_picker #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .valid_i (req.req_valid),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .any_o   (pick_any)
  );

  // Mux of the granted requester's word (grant_q is one-hot).
  always_comb begin
    sel_valid = 1'b0;
    sel_cmd   = 1'b0;
    sel_data  = '0;
    g_idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        sel_valid = req.req_valid[i];
        sel_cmd   = req.req_is_cmd[i];
        sel_data  = req.req_data[i*DATA_W +: DATA_W];
        g_idx     = PW'(i);
      end
    end
  end

  assign at_max = (cnt_q == CW'(MAX_ARGS));

  always_comb begin
    alu.alu_valid  = 1'b0;
    alu.alu_data   = '0;
    alu.alu_is_cmd = 1'b0;
    req.req_ready  = '0;
    unique case (state_q)
      FWD: begin
        // A data word beyond the limit is held back, not forwarded.
        if (!(sel_valid && !sel_cmd && at_max)) begin
          alu.alu_valid  = sel_valid;
          alu.alu_data   = sel_data;
          alu.alu_is_cmd = sel_cmd;
          req.req_ready  = grant_q & {N_REQ{alu.alu_ready}};
        end
      end
      ABORT: begin
        alu.alu_valid  = 1'b1;
        alu.alu_is_cmd = 1'b1;
        alu.alu_data   = DATA_W'(CMD_NOP);
      end
      DRAIN:   req.req_ready = grant_q;
      default: ;
    endcase
    req.rsp_valid  = (state_q == RSP) ? grant_q : '0;
    req.rsp_data   = rsp_data_q;
    req.rsp_status = rsp_status_q;
    grant          = grant_q;
    busy           = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      ptr_q        <= PW'(N_REQ - 1);
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
`ifdef VDIC_ALU_ARB_RSP_TIMEOUT_EN
      wd_q         <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (pick_any) begin
          grant_q <= pick_gnt;
          state_q <= FWD;
        end
        FWD: if (sel_valid) begin
          if (sel_cmd) begin
            if (alu.alu_ready) state_q <= WAIT_RSP;
          end else if (at_max) begin
            state_q <= ABORT;
          end else if (alu.alu_ready) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ABORT: if (alu.alu_ready) begin
          ovf_q   <= 1'b1;
          state_q <= DRAIN;
        end
        DRAIN: if (sel_valid && sel_cmd) state_q <= WAIT_RSP;
        WAIT_RSP: begin
          // A response on the expiry cycle takes priority over the timeout.
          if (alu.alu_rsp_valid) begin
            rsp_data_q   <= ovf_q ? '0 : alu.alu_rsp_data;
            rsp_status_q <= ovf_q ? S_DATA_STACK_OVERFLOW : alu.alu_rsp_status;
            state_q      <= RSP;
`ifdef VDIC_ALU_ARB_RSP_TIMEOUT_EN
            wd_q         <= '0;
          end else if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
            rsp_data_q   <= '0;
            rsp_status_q <= S_RSP_TIMEOUT;
            state_q      <= RSP;
            wd_q         <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
`endif
          end
        end
        RSP: if ((grant_q & req.rsp_ready) != '0) begin
          ptr_q   <= g_idx;
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdic_alu_arbiter.sv
// Scoreboard bench for vdic_alu_arbiter: directed frames are queued per
// requester, expected ALU words and responses go into queues, and a
// monitor compares whatever the DUT presents against them.
module tb_vdic_alu_arbiter;
  import vdic_dut_pkg::*;

  localparam int N_REQ  = 2;
  localparam int DATA_W = 32;
  localparam int TO     = 16;

  typedef struct packed { logic cmd; logic [DATA_W-1:0] data; } word_t;
  typedef struct packed { logic [3:0] idx; logic [DATA_W-1:0] data; logic [7:0] st; } rsp_t;
  typedef struct packed { logic [DATA_W-1:0] data; logic [7:0] st; } arsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vdic_req_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) rif();
  vdic_alu_if #(.DATA_W(DATA_W)) aif();
  logic [N_REQ-1:0] grant;
  logic             busy;

  vdic_alu_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_ARGS(9), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(rif), .alu(aif), .grant(grant), .busy(busy)
  );

  word_t rq [N_REQ][$];
  word_t exp_alu[$];
  rsp_t  exp_rsp[$];
  arsp_t alu_rq[$];

  int chk = 0, err = 0, cyc = 0, cmd_cyc = 0, rsp_lat = 0;
  int stall_cnt = 0, rsp_dly = 0, alu_pend = 0, alu_dly = 0;
  int rwait [N_REQ];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic req_w(int r, logic c, logic [DATA_W-1:0] d);
    rq[r].push_back('{cmd: c, data: d});
  endtask
  task automatic alu_w(logic c, logic [DATA_W-1:0] d);
    exp_alu.push_back('{cmd: c, data: d});
  endtask
  task automatic exp_r(int idx, logic [DATA_W-1:0] d, logic [7:0] st);
    exp_rsp.push_back('{idx: 4'(idx), data: d, st: st});
  endtask
  task automatic alu_r(logic [DATA_W-1:0] d, logic [7:0] st);
    alu_rq.push_back('{data: d, st: st});
  endtask

  // Requester and ALU models: sample at negedge, drive 1 after posedge.
  initial begin
    logic [N_REQ-1:0] tk;
    word_t w;
    arsp_t a;
    rif.req_valid = '0; rif.req_data = '0; rif.req_is_cmd = '0; rif.rsp_ready = '1;
    aif.alu_ready = 1'b1; aif.alu_rsp_valid = 1'b0;
    aif.alu_rsp_data = '0; aif.alu_rsp_status = '0;
    for (int r = 0; r < N_REQ; r++) rwait[r] = 0;
    forever begin
      @(negedge clk);
      tk = rif.req_valid & rif.req_ready;
      for (int r = 0; r < N_REQ; r++)
        if (!rif.rsp_valid[r] || rif.rsp_ready[r]) rwait[r] = 0; else rwait[r]++;
      if (rst_n && aif.alu_valid && aif.alu_ready && aif.alu_is_cmd) begin
        alu_pend = 1; alu_dly = 4;
      end
      @(posedge clk); #1;
      for (int r = 0; r < N_REQ; r++) begin
        if (tk[r] && rq[r].size() > 0) void'(rq[r].pop_front());
        if (rq[r].size() > 0) begin
          w = rq[r][0];
          rif.req_valid[r] = 1'b1;
          rif.req_is_cmd[r] = w.cmd;
          rif.req_data[r*DATA_W +: DATA_W] = w.data;
        end else begin
          rif.req_valid[r] = 1'b0;
          rif.req_is_cmd[r] = 1'b0;
        end
        rif.rsp_ready[r] = (rwait[r] >= rsp_dly);
      end
      aif.alu_ready = (stall_cnt == 0);
      if (stall_cnt > 0) stall_cnt--;
      aif.alu_rsp_valid = 1'b0;
      if (alu_pend != 0) begin
        if (alu_dly > 0) alu_dly--;
        else begin
          alu_pend = 0;
          if (alu_rq.size() > 0) begin
            a = alu_rq.pop_front();
            aif.alu_rsp_valid = 1'b1;
            aif.alu_rsp_data = a.data;
            aif.alu_rsp_status = a.st;
          end
        end
      end
    end
  end

  // Monitor: ALU words, responses, response hold, grant stability.
  initial begin
    word_t w;
    rsp_t e;
    logic held = 1'b0, pbusy = 1'b0;
    logic [DATA_W-1:0] hd;
    logic [7:0] hs;
    logic [N_REQ-1:0] pg = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        held = 1'b0; pbusy = 1'b0;
      end else begin
        if (aif.alu_valid && aif.alu_ready) begin
          if (aif.alu_is_cmd) cmd_cyc = cyc;
          if (exp_alu.size() == 0) begin
            chk++; err++;
            $display("FAIL alu_extra: got cmd=%0b data=%0h expected none", aif.alu_is_cmd, aif.alu_data);
          end else begin
            w = exp_alu.pop_front();
            check("alu_word", 64'({aif.alu_is_cmd, aif.alu_data}), 64'(w));
          end
        end
        if (busy && pbusy) check("grant_stable", 64'(grant), 64'(pg));
        pbusy = busy; pg = grant;
        if (rif.rsp_valid != '0) begin
          if (!held) begin
            held = 1'b1; hd = rif.rsp_data; hs = rif.rsp_status; rsp_lat = cyc - cmd_cyc;
          end else begin
            check("rsp_hold", 64'({rif.rsp_data, rif.rsp_status}), 64'({hd, hs}));
          end
          if ((rif.rsp_valid & rif.rsp_ready) != '0) begin
            held = 1'b0;
            if (exp_rsp.size() == 0) begin
              chk++; err++;
              $display("FAIL rsp_unexpected: got valid=%0b data=%0h expected none", rif.rsp_valid, rif.rsp_data);
            end else begin
              e = exp_rsp.pop_front();
              check("rsp_dest", 64'(rif.rsp_valid), 64'(1) << e.idx);
              check("rsp_grant", 64'(grant), 64'(1) << e.idx);
              check("rsp_data", 64'(rif.rsp_data), 64'(e.data));
              check("rsp_status", 64'(rif.rsp_status), 64'(e.st));
            end
          end
        end
      end
    end
  end

  task automatic wait_busy(string name);
    int n = 0;
    while (!busy && n < 50) begin @(negedge clk); n++; end
    if (!busy) begin
      chk++; err++;
      $display("FAIL %s: got busy=0 expected busy=1 within 50 cycles", name);
    end
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (n < 400 && (busy || exp_alu.size() != 0 || exp_rsp.size() != 0 ||
                       rq[0].size() != 0 || rq[1].size() != 0));
    if (n >= 400) begin
      chk++; err++;
      $display("FAIL %s: got alu_left=%0d rsp_left=%0d expected 0 within 400 cycles",
               name, exp_alu.size(), exp_rsp.size());
    end
  endtask

  initial begin
    logic quiet;
    repeat (3) @(posedge clk); #2;
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rsp_valid", 64'(rif.rsp_valid), 64'(0));
    check("rst_alu_valid", 64'(aif.alu_valid), 64'(0));
    rst_n = 1'b1;

    // Basic ADD frame from requester 0.
    req_w(0, 0, 5); req_w(0, 0, 3); req_w(0, 1, 32'(CMD_ADD));
    alu_w(0, 5); alu_w(0, 3); alu_w(1, 32'(CMD_ADD));
    alu_r(8, 8'h00); exp_r(0, 8, 8'h00);
    wait_busy("t1_busy");
    check("t1_grant", 64'(grant), 64'(2'b01));
    check("t1_idle_ready", 64'(rif.req_ready[1]), 64'(0));
    wait_idle("t1_done");

    // Contention from reset: order req0, req1, req0, req1.
    @(posedge clk); #2; rst_n = 1'b0;
    req_w(0, 0, 1); req_w(0, 0, 2); req_w(0, 1, 32'(CMD_AND));
    req_w(0, 0, 32'hF0); req_w(0, 0, 32'hFF); req_w(0, 1, 32'(CMD_XOR));
    req_w(1, 0, 6); req_w(1, 0, 3); req_w(1, 1, 32'(CMD_OR));
    req_w(1, 0, 10); req_w(1, 0, 4); req_w(1, 1, 32'(CMD_SUB));
    alu_w(0, 1); alu_w(0, 2); alu_w(1, 32'(CMD_AND));
    alu_w(0, 6); alu_w(0, 3); alu_w(1, 32'(CMD_OR));
    alu_w(0, 32'hF0); alu_w(0, 32'hFF); alu_w(1, 32'(CMD_XOR));
    alu_w(0, 10); alu_w(0, 4); alu_w(1, 32'(CMD_SUB));
    alu_r(0, 0); alu_r(7, 0); alu_r(32'h0F, 0); alu_r(6, 0);
    exp_r(0, 0, 0); exp_r(1, 7, 0); exp_r(0, 32'h0F, 0); exp_r(1, 6, 0);
    repeat (2) @(posedge clk); #2; rst_n = 1'b1;
    wait_idle("t2_done");

    // Overlong frame from requester 1: 9 words + NOP reach the ALU.
    for (int i = 1; i <= 10; i++) req_w(1, 0, 32'(i));
    req_w(1, 1, 32'(CMD_XOR));
    for (int i = 1; i <= 9; i++) alu_w(0, 32'(i));
    alu_w(1, 32'(CMD_NOP));
    alu_r(32'hAAAA, 8'h00); exp_r(1, 0, 8'h02);
    wait_idle("t3_done");

    // Command-only frame, ALU status passed through.
    req_w(0, 1, 32'(CMD_SUB)); alu_w(1, 32'(CMD_SUB));
    alu_r(32'hDEAD, 8'h01); exp_r(0, 32'hDEAD, 8'h01);
    wait_idle("t4_done");

    // ALU stall mid-frame and delayed response take.
    rsp_dly = 3;
    req_w(0, 0, 7); req_w(0, 0, 9); req_w(0, 0, 11); req_w(0, 1, 32'(CMD_ADD));
    alu_w(0, 7); alu_w(0, 9); alu_w(0, 11); alu_w(1, 32'(CMD_ADD));
    alu_r(27, 8'h00); exp_r(0, 27, 8'h00);
    for (int n = 0; n < 50 && exp_alu.size() > 3; n++) @(negedge clk);
    stall_cnt = 5;
    wait_idle("t5_done");
    rsp_dly = 0;

`ifdef VDIC_ALU_ARB_RSP_TIMEOUT_EN
    // Silent ALU: watchdog answers after TO cycles in WAIT_RSP.
    req_w(0, 1, 32'(CMD_AND)); alu_w(1, 32'(CMD_AND));
    exp_r(0, 0, 8'h08);
    wait_idle("t6_done");
    check("t6_latency", 64'(rsp_lat), 64'(TO + 1));
`endif

    // Reset in the middle of a frame.
    stall_cnt = 1000;
    req_w(0, 0, 1); req_w(0, 0, 2); req_w(0, 1, 32'(CMD_ADD));
    alu_w(0, 1); alu_w(0, 2); alu_w(1, 32'(CMD_ADD));
    wait_busy("t7_busy");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t7_grant", 64'(grant), 64'(0));
    check("t7_busy", 64'(busy), 64'(0));
    check("t7_rsp_valid", 64'(rif.rsp_valid), 64'(0));
    rq[0].delete(); exp_alu.delete(); stall_cnt = 0; alu_pend = 0;
    repeat (2) @(posedge clk); #2; rst_n = 1'b1;
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (busy || rif.rsp_valid != '0) quiet = 1'b0;
    end
    check("t7_quiet", 64'(quiet), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "global timeout");
  end

endmodule
